// File: rtl/ar_issue_if.sv
// AR issue stage bus bundle: FIFO pop side, AXI AR channel and monitored R
// channel handshake. The issue stage uses the master view, the environment
// (FIFO plus downstream slave) uses the slave view.
interface ar_issue_if #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 4,
    parameter int SIZE_WIDTH = 3
);
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic [ID_WIDTH-1:0]   fifo_ARID;
    logic [ADDR_WIDTH-1:0] fifo_ARADDR;
    logic [LEN_WIDTH-1:0]  fifo_ARLEN;
    logic [SIZE_WIDTH-1:0] fifo_ARSIZE;
    logic [1:0]            fifo_ARBURST;

    logic [ID_WIDTH-1:0]   M_ARID;
    logic [ADDR_WIDTH-1:0] M_ARADDR;
    logic [LEN_WIDTH-1:0]  M_ARLEN;
    logic [SIZE_WIDTH-1:0] M_ARSIZE;
    logic [1:0]            M_ARBURST;
    logic                  M_ARVALID;
    logic                  M_ARREADY;

    logic                  M_RVALID;
    logic                  M_RREADY;
    logic                  M_RLAST;

    modport master (
        input  fifo_empty, fifo_ARID, fifo_ARADDR, fifo_ARLEN, fifo_ARSIZE, fifo_ARBURST,
        output fifo_pop,
        output M_ARID, M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST, M_ARVALID,
        input  M_ARREADY,
        input  M_RVALID, M_RREADY, M_RLAST
    );

    modport slave (
        output fifo_empty, fifo_ARID, fifo_ARADDR, fifo_ARLEN, fifo_ARSIZE, fifo_ARBURST,
        input  fifo_pop,
        input  M_ARID, M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST, M_ARVALID,
        output M_ARREADY,
        output M_RVALID, M_RREADY, M_RLAST
    );
endinterface

// File: rtl/ar_issue.sv
// AR issue stage, rx clock domain. Pops the fall-through AR FIFO into an
// output register, drives the AR handshake and limits outstanding read bursts
// with a credit counter released on each R last-beat handshake.
// Optional stall watchdog: define AR_ISSUE_TIMEOUT_EN.
//
// state   | meaning
// --------+--------------------------------------------------
// S_EMPTY | output register empty, M_ARVALID=0
// S_HOLD  | request held in output register, M_ARVALID=1
module ar_issue #(
    parameter int   ID_WIDTH        = 4,
    parameter int   ADDR_WIDTH      = 32,
    parameter int   LEN_WIDTH       = 4,
    parameter int   SIZE_WIDTH      = 3,
    parameter int   MAX_OUTSTANDING = 4,
    parameter int   TIMEOUT_CYCLES  = 1024,
    localparam int  CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk_rx,
    input  logic             rst_rx,
    ar_issue_if.master       bus,
    output logic [CNT_W-1:0] outstanding,
    output logic             idle,
    output logic             timeout
);
    typedef enum logic {S_EMPTY = 1'b0, S_HOLD = 1'b1} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    if (MAX_OUTSTANDING < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("ar_issue: MAX_OUTSTANDING must be >=1 and TIMEOUT_CYCLES >=2");
    end

    state_t                state_q, state_d;
    logic [ID_WIDTH-1:0]   arid_q, arid_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [LEN_WIDTH-1:0]  arlen_q, arlen_d;
    logic [SIZE_WIDTH-1:0] arsize_q, arsize_d;
    logic [1:0]            arburst_q, arburst_d;
    logic [CNT_W-1:0]      outstanding_q, outstanding_d;
    logic                  pop;
    logic                  handshake;
    logic                  rdone;

    // Pop/handshake decode, next state, payload load and credit update.
    // The credit check uses the registered count only, so a same-cycle
    // rdone never unlocks a pop at the limit.
    always_comb begin
        state_d       = state_q;
        arid_d        = arid_q;
        araddr_d      = araddr_q;
        arlen_d       = arlen_q;
        arsize_d      = arsize_q;
        arburst_d     = arburst_q;
        outstanding_d = outstanding_q;

        rdone     = bus.M_RVALID && bus.M_RREADY && bus.M_RLAST;
        handshake = (state_q == S_HOLD) && bus.M_ARREADY;
        pop       = !bus.fifo_empty && ((state_q == S_EMPTY) || bus.M_ARREADY)
                    && (outstanding_q < MAX_CNT);

        case (state_q)
            S_EMPTY: if (pop) state_d = S_HOLD;
            S_HOLD:  if (handshake && !pop) state_d = S_EMPTY;
            default: state_d = S_EMPTY;
        endcase

        if (pop) begin
            arid_d    = bus.fifo_ARID;
            araddr_d  = bus.fifo_ARADDR;
            arlen_d   = bus.fifo_ARLEN;
            arsize_d  = bus.fifo_ARSIZE;
            arburst_d = bus.fifo_ARBURST;
        end

        case ({pop, rdone})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   if (outstanding_q != '0) outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    // State, payload and credit registers.
    always_ff @(posedge clk_rx or posedge rst_rx) begin
        if (rst_rx) begin
            state_q       <= S_EMPTY;
            arid_q        <= '0;
            araddr_q      <= '0;
            arlen_q       <= '0;
            arsize_q      <= '0;
            arburst_q     <= '0;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            arid_q        <= arid_d;
            araddr_q      <= araddr_d;
            arlen_q       <= arlen_d;
            arsize_q      <= arsize_d;
            arburst_q     <= arburst_d;
            outstanding_q <= outstanding_d;
        end
    end

    assign bus.fifo_pop  = pop;
    assign bus.M_ARVALID = (state_q == S_HOLD);
    assign bus.M_ARID    = arid_q;
    assign bus.M_ARADDR  = araddr_q;
    assign bus.M_ARLEN   = arlen_q;
    assign bus.M_ARSIZE  = arsize_q;
    assign bus.M_ARBURST = arburst_q;
    assign outstanding   = outstanding_q;
    assign idle          = (outstanding_q == '0) && (state_q == S_EMPTY);

`ifdef AR_ISSUE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] stall_cnt_q, stall_cnt_d;
    logic            timeout_q, timeout_d;
    logic            stall;

    // Stall run length, saturating at the limit; flag is sticky until reset.
    always_comb begin
        stall       = (state_q == S_HOLD) && !bus.M_ARREADY;
        stall_cnt_d = '0;
        if (stall) begin
            stall_cnt_d = (stall_cnt_q == TO_LAST) ? stall_cnt_q : stall_cnt_q + TO_W'(1);
        end
        timeout_d = timeout_q || (stall_cnt_d == TO_LAST);
    end

    // Watchdog registers.
    always_ff @(posedge clk_rx or posedge rst_rx) begin
        if (rst_rx) begin
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

`ifndef SYNTHESIS
    // A last beat with nothing outstanding means the slave broke protocol.
    a_no_rdone_underflow: assert property (@(posedge clk_rx) disable iff (rst_rx)
        !(rdone && (outstanding_q == '0)));
`endif

endmodule

// File: tb/tb_ar_issue.sv
module tb_ar_issue;
    localparam int IW   = 4;
    localparam int AW   = 32;
    localparam int LW   = 4;
    localparam int SW   = 3;
    localparam int MAXO = 4;
    localparam int TO   = 8;
    localparam int CW   = $clog2(MAXO + 1);

    typedef struct packed {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic [SW-1:0] size;
        logic [1:0]    burst;
    } pay_t;

    typedef struct {
        int push;
        bit ardy, rv, rr, rl;
        bit x_pop, x_vld;
        int x_out;
        bit x_idle;
    } vec_t;

    logic clk_rx = 1'b0;
    logic rst_rx = 1'b1;
    always #5 clk_rx = ~clk_rx;

    ar_issue_if #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .SIZE_WIDTH(SW)) bus();
    logic [CW-1:0] outstanding;
    logic          idle;
    logic          timeout;

    ar_issue #(
        .ID_WIDTH(IW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .SIZE_WIDTH(SW),
        .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_rx(clk_rx),
        .rst_rx(rst_rx),
        .bus(bus),
        .outstanding(outstanding),
        .idle(idle),
        .timeout(timeout)
    );

    // Reference model: FIFO contents, the request the slave should see,
    // credits in flight and the current stall run length.
    pay_t fq[$];
    bit   m_vld;
    pay_t m_pay;
    int   m_cnt;
    int   m_run;
    bit   m_sticky;

    bit   obs_pop, obs_vld, obs_idle, obs_to;
    int   obs_out;

    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic pay_t rand_pay();
        pay_t p;
        p.id    = IW'($urandom);
        p.addr  = AW'($urandom);
        p.len   = LW'($urandom);
        p.size  = SW'($urandom);
        p.burst = 2'($urandom);
        return p;
    endfunction

    task automatic model_clear();
        fq.delete();
        m_vld    = 1'b0;
        m_pay    = '0;
        m_cnt    = 0;
        m_run    = 0;
        m_sticky = 1'b0;
    endtask

    // One clock: drive at posedge+1, check at negedge, advance model at posedge.
    task automatic cycle(input bit ardy, input bit rv, input bit rr, input bit rl);
        bit e_pop, e_to, rdone, hs, stall;
        int run_cur;
        bus.fifo_empty = (fq.size() == 0);
        if (fq.size() != 0)
            {bus.fifo_ARID, bus.fifo_ARADDR, bus.fifo_ARLEN, bus.fifo_ARSIZE, bus.fifo_ARBURST} = fq[0];
        else
            {bus.fifo_ARID, bus.fifo_ARADDR, bus.fifo_ARLEN, bus.fifo_ARSIZE, bus.fifo_ARBURST} = '0;
        bus.M_ARREADY = ardy;
        bus.M_RVALID  = rv;
        bus.M_RREADY  = rr;
        bus.M_RLAST   = rl;

        @(negedge clk_rx);
        rdone   = rv && rr && rl;
        e_pop   = (fq.size() != 0) && (!m_vld || ardy) && (m_cnt < MAXO);
        stall   = m_vld && !ardy;
        run_cur = stall ? m_run + 1 : 0;
`ifdef AR_ISSUE_TIMEOUT_EN
        e_to = m_sticky || (run_cur >= TO);
`else
        e_to = 1'b0;
`endif
        chk("fifo_pop", 64'(bus.fifo_pop), 64'(e_pop));
        chk("arvalid", 64'(bus.M_ARVALID), 64'(m_vld));
        if (m_vld)
            chk("ar_payload",
                64'({bus.M_ARID, bus.M_ARADDR, bus.M_ARLEN, bus.M_ARSIZE, bus.M_ARBURST}),
                64'(m_pay));
        chk("outstanding", 64'(outstanding), 64'(m_cnt));
        chk("idle", 64'(idle), 64'((m_cnt == 0) && !m_vld));
        chk("timeout", 64'(timeout), 64'(e_to));
        obs_pop  = bus.fifo_pop;
        obs_vld  = bus.M_ARVALID;
        obs_out  = int'(outstanding);
        obs_idle = idle;
        obs_to   = timeout;

        @(posedge clk_rx);
        hs = m_vld && ardy;
        if (e_pop) begin
            m_pay = fq.pop_front();
            m_vld = 1'b1;
        end else if (hs) begin
            m_vld = 1'b0;
        end
        m_cnt = m_cnt + int'(e_pop) - int'(rdone);
        if (m_cnt < 0) m_cnt = 0;
        m_run    = run_cur;
        m_sticky = e_to;
        #1;
    endtask

    task automatic push_n(input int n);
        for (int i = 0; i < n; i++) fq.push_back(rand_pay());
    endtask

    task automatic drain();
        while (m_cnt > 0) cycle(1'b0, 1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

    vec_t tbl[16];
    bit [4:0] pm, vm;
    bit [9:0] tm, tm_exp;
    int pc;

    initial begin
        tbl[0]  = '{6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1};
        tbl[1]  = '{0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0};
        tbl[2]  = '{0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2, 1'b0};
        tbl[3]  = '{0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3, 1'b0};
        tbl[4]  = '{0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b0};
        tbl[5]  = '{0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b0};
        tbl[6]  = '{0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4, 1'b0};
        tbl[7]  = '{0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3, 1'b0};
        tbl[8]  = '{0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4, 1'b0};
        tbl[9]  = '{0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3, 1'b0};
        tbl[10] = '{0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b0};
        tbl[11] = '{0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b0};
        tbl[12] = '{0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3, 1'b0};
        tbl[13] = '{0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2, 1'b0};
        tbl[14] = '{0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b0};
        tbl[15] = '{0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1};

        bus.fifo_empty = 1'b1;
        {bus.fifo_ARID, bus.fifo_ARADDR, bus.fifo_ARLEN, bus.fifo_ARSIZE, bus.fifo_ARBURST} = '0;
        bus.M_ARREADY = 1'b0;
        bus.M_RVALID  = 1'b0;
        bus.M_RREADY  = 1'b0;
        bus.M_RLAST   = 1'b0;
        model_clear();
        repeat (3) @(posedge clk_rx);
        @(negedge clk_rx);
        rst_rx = 1'b0;
        @(posedge clk_rx);
        #1;

        // Reset state
        chk("reset_payload",
            64'({bus.M_ARID, bus.M_ARADDR, bus.M_ARLEN, bus.M_ARSIZE, bus.M_ARBURST}), 64'(0));
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Credit limit table
        for (int i = 0; i < 16; i++) begin
            push_n(tbl[i].push);
            cycle(tbl[i].ardy, tbl[i].rv, tbl[i].rr, tbl[i].rl);
            chk($sformatf("tbl%0d_pop", i), 64'(obs_pop), 64'(tbl[i].x_pop));
            chk($sformatf("tbl%0d_vld", i), 64'(obs_vld), 64'(tbl[i].x_vld));
            chk($sformatf("tbl%0d_out", i), 64'(obs_out), 64'(tbl[i].x_out));
            chk($sformatf("tbl%0d_idle", i), 64'(obs_idle), 64'(tbl[i].x_idle));
        end

        // Reset in the middle of a stall with two bursts outstanding
        push_n(2);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_vld", 64'(bus.M_ARVALID), 64'(1));
        chk("pre_rst_out", 64'(outstanding), 64'(2));
        #2;
        rst_rx = 1'b1;
        #1;
        chk("async_rst_vld", 64'(bus.M_ARVALID), 64'(0));
        chk("async_rst_out", 64'(outstanding), 64'(0));
        chk("async_rst_idle", 64'(idle), 64'(1));
        model_clear();
        @(negedge clk_rx);
        rst_rx = 1'b0;
        @(posedge clk_rx);
        #1;

        // Single request followed by a 4-beat read
        fq.push_back('{id: 4'd3, addr: 32'h1000, len: 4'd3, size: 3'd2, burst: 2'd1});
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("single_pop", 64'(obs_pop), 64'(1));
        chk("single_payload",
            64'({bus.M_ARID, bus.M_ARADDR, bus.M_ARLEN, bus.M_ARSIZE, bus.M_ARBURST}),
            64'({4'd3, 32'h1000, 4'd3, 3'd2, 2'd1}));
        chk("single_vld", 64'(bus.M_ARVALID), 64'(1));
        chk("single_out", 64'(outstanding), 64'(1));
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int b = 0; b < 4; b++) cycle(1'b0, 1'b1, 1'b1, b == 3);
        chk("single_done_out", 64'(outstanding), 64'(0));
        chk("single_done_idle", 64'(idle), 64'(1));

        // Throughput: one request per cycle
        push_n(4);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
            pm[i] = obs_pop;
            vm[i] = obs_vld;
        end
        chk("thru_pop_mask", 64'(pm), 64'(5'b01111));
        chk("thru_vld_mask", 64'(vm), 64'(5'b11110));
        chk("thru_out", 64'(outstanding), 64'(4));
        drain();

        // Backpressure: five stalled cycles, then release
        push_n(2);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        pc = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            pc += int'(obs_pop);
        end
        chk("bp_no_pop", 64'(pc), 64'(0));
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("bp_release_pop", 64'(obs_pop), 64'(1));
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("bp_second_issued", 64'(obs_vld), 64'(1));
        drain();

        // Watchdog: stuck ARREADY
        push_n(1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            tm[i] = obs_to;
        end
`ifdef AR_ISSUE_TIMEOUT_EN
        tm_exp = 10'b11_1000_0000;
`else
        tm_exp = 10'b0;
`endif
        chk("timeout_mask", 64'(tm), 64'(tm_exp));
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("timeout_sticky", 64'(obs_to), 64'(tm_exp[9]));
        drain();

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            bit ardy, rv, rr, rl;
            if (($urandom_range(0, 2) == 0) && (fq.size() < 8)) push_n(1);
            ardy = (i % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            rv   = $urandom_range(0, 1) != 0;
            rr   = $urandom_range(0, 1) != 0;
            rl   = (m_cnt > 0) && ($urandom_range(0, 1) != 0);
            cycle(ardy, rv, rr, rl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
